if_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-entry PC register / IF-ID latch pair with a DEPTH-entry prefetch queue. It owns the fetch PC, issues one ROM read per cycle while queue credit exists, buffers returned instructions with their PCs, and presents them to ID through a valid/ready handshake. A branch redirect from EX flushes all buffered and in-flight wrong-path instructions and restarts fetch at the target.

---
 rtl/if_prefetch_queue.sv | 128 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end with a DEPTH-entry prefetch
// queue. Owns the fetch PC, issues one ROM read per cycle while the queue has
// credit, buffers {pc, inst} pairs and hands them to ID over valid/ready.
// A redirect from EX flushes buffered and in-flight wrong-path work.
//
// Optional feature macro: IF_PREFETCH_BYPASS_EN
//   defined   : an empty queue forwards the returning ROM word straight to ID
//               in the same cycle (adds a rom_data_i -> id_* combinational path)
//   undefined : ID is fed from storage only
module if_prefetch_queue #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            INST_WIDTH = 32,
  parameter int unsigned            DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            PC_STEP    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [ADDR_WIDTH-1:0]      rom_addr_o,
  input  logic [INST_WIDTH-1:0]      rom_data_i,
  input  logic                       branch_i,
  input  logic [ADDR_WIDTH-1:0]      branch_addr_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [ADDR_WIDTH-1:0]      id_pc_o,
  output logic [INST_WIDTH-1:0]      id_inst_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [CW:0]           occ;
  logic                  push_vld;
  logic                  byp;
  logic                  pop;
  logic                  wr;

  // Issue credit, ID presentation and handshake decode.
  always_comb begin
    // Credit counts the in-flight read; a pop in the same cycle is not credited,
    // so the queue can never overflow.
    occ        = (CW+1)'(count_q) + (CW+1)'(inflight_q);
    rom_ce_o   = !rst && (occ < (CW+1)'(DEPTH));
    rom_addr_o = fetch_pc_q;
    // A response is only worth keeping if no redirect is happening right now.
    push_vld   = inflight_q && !branch_i;
`ifdef IF_PREFETCH_BYPASS_EN
    byp        = push_vld && (count_q == '0);
`else
    byp        = 1'b0;
`endif
    id_valid_o = ((count_q != '0) || byp) && !branch_i;
    id_pc_o    = byp ? inflight_pc_q : mem_q[rd_ptr_q].pc;
    id_inst_o  = byp ? rom_data_i    : mem_q[rd_ptr_q].inst;
    // Storage pop only when the head came from storage.
    pop        = id_valid_o && id_ready_i && !byp;
    // A bypassed word consumed by ID is never written.
    wr         = push_vld && !(byp && id_ready_i);
    count_o    = count_q;
  end

  // Next-state: redirect wins over push, pop and the issue increment.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];

    if (branch_i) begin
      fetch_pc_d = branch_addr_i;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = rom_ce_o;
      if (rom_ce_o) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
      end
      if (wr) mem_d[wr_ptr_q] = '{pc: inflight_pc_q, inst: rom_data_i};
      wr_ptr_d = wr_ptr_q + PW'(wr);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(wr) - CW'(pop);
    end
  end

  // State registers; reset clears everything including storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: a synchronous ROM model answers
// reads, expected PCs are queued as each phase is set up and popped whenever ID
// accepts an entry.
module tb_if_prefetch_queue;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce_o;
  logic [AW-1:0] rom_addr_o;
  logic [IW-1:0] rom_data_i = '0;
  logic          branch_i;
  logic [AW-1:0] branch_addr_i;
  logic          id_valid_o;
  logic          id_ready_i;
  logic [AW-1:0] id_pc_o;
  logic [IW-1:0] id_inst_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];

  if_prefetch_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH),
                      .RESET_PC('0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] romf(input logic [AW-1:0] a);
    return (a * 32'd3) ^ 32'hA5C3_0F1E;
  endfunction

  // Synchronous ROM: data for a request appears the cycle after it.
  always @(posedge clk) rom_data_i <= rom_ce_o ? romf(rom_addr_o) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pop on every accepted ID transfer.
  task automatic mon();
    logic [AW-1:0] e;
    bit has;
    if (!rst && id_valid_o && id_ready_i) begin
      has = (exp_q.size() != 0);
      chk("sb_avail", has, 1);
      if (has) begin
        e = exp_q.pop_front();
        chk("pop_pc", id_pc_o, e);
        chk("pop_inst", id_inst_o, romf(e));
      end
    end
  endtask

  task automatic clk_n(); @(negedge clk); mon(); endtask
  task automatic clk_p(); @(posedge clk); #1; endtask

  task automatic push_seq(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + AW'(4 * i));
  endtask

  task automatic drain(input string tag, input int bound, input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      clk_n();
      clk_p();
      if (rnd) id_ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    id_ready_i = 1'b0;
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_count(input string tag, input int target, input int bound);
    int n = 0;
    forever begin
      clk_n();
      if (int'(count_o) == target || n >= bound) break;
      clk_p();
      n++;
    end
    chk(tag, count_o, target);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"},    rom_ce_o,   0);
    chk({tag, "_addr"},  rom_addr_o, 0);
    chk({tag, "_valid"}, id_valid_o, 0);
    chk({tag, "_pc"},    id_pc_o,    0);
    chk({tag, "_inst"},  id_inst_o,  0);
    chk({tag, "_count"}, count_o,    0);
  endtask

  task automatic redirect(input string tag, input logic [AW-1:0] tgt);
    clk_p();
    branch_i = 1'b1;
    branch_addr_i = tgt;
    clk_n();
    chk({tag, "_mask"}, id_valid_o, 0);
    clk_p();
    branch_i = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    bit got;
    logic [AW-1:0] e;
    rst = 1'b1; id_ready_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;

    // Reset state
    clk_n();
    chk_reset("rst");

    // Streaming with ID always ready: one per cycle after fetch latency
    push_seq(0, 20);
    id_ready_i = 1'b1;
    clk_p();
    rst = 1'b0;
    for (int k = 0; k < LAT + 20; k++) begin
      clk_n();
      if (k == 0) begin
        chk("A_first_ce", rom_ce_o, 1);
        chk("A_first_addr", rom_addr_o, 0);
      end
      if (k < LAT) chk("A_lat", id_valid_o, 0);
      else         chk("A_stream", id_valid_o, 1);
      clk_p();
    end
    id_ready_i = 1'b0;
    chk("A_drain", exp_q.size(), 0);

    // ID stalled from reset: exactly DEPTH requests, then resume in order
    rst = 1'b1;
    clk_p();
    rst = 1'b0;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      clk_n();
      if (rom_ce_o) begin
        chk("B_addr", rom_addr_o, 4 * nreq);
        nreq++;
      end
      clk_p();
    end
    chk("B_nreq", nreq, DEPTH);
    chk("B_count", count_o, DEPTH);
    chk("B_ce_off", rom_ce_o, 0);
    push_seq(0, 12);
    id_ready_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      clk_n();
      if (rom_ce_o) begin
        chk("B_resume_addr", rom_addr_o, 32'h10);
        got = 1'b1;
        break;
      end
      clk_p();
    end
    chk("B_resume_seen", got, 1);
    drain("B_drain", 80, 1'b0);

    // Async reset mid-operation with count 2 and a response pending
    rst = 1'b1;
    clk_p();
    rst = 1'b0;
    wait_count("F_count2", 2, 20);
    #1 rst = 1'b1;
    #1 chk_reset("F_async");
    clk_p();
    rst = 1'b0;
    push_seq(0, 8);
    id_ready_i = 1'b1;
    clk_n();
    chk("F_restart_ce", rom_ce_o, 1);
    chk("F_restart_addr", rom_addr_o, 0);
    drain("F_drain", 60, 1'b0);

    // Redirect with count 3 and a read in flight
    wait_count("C_count3", 3, 20);
    branch_i = 1'b1;
    branch_addr_i = 32'h100;
    #1 chk("C_mask", id_valid_o, 0);
    clk_p();
    branch_i = 1'b0;
    exp_q.delete();
    push_seq(32'h100, 8);
    clk_n();
    chk("C_count", count_o, 0);
    chk("C_ce", rom_ce_o, 1);
    chk("C_addr", rom_addr_o, 32'h100);
    id_ready_i = 1'b1;
    drain("C_drain", 60, 1'b0);

    // Back-to-back redirects: last one wins
    for (int k = 0; k < 3; k++) clk_p();
    branch_i = 1'b1;
    branch_addr_i = 32'h200;
    clk_n();
    chk("D_mask1", id_valid_o, 0);
    clk_p();
    branch_addr_i = 32'h300;
    clk_n();
    chk("D_mask2", id_valid_o, 0);
    chk("D_addr200", rom_addr_o, 32'h200);
    clk_p();
    branch_i = 1'b0;
    exp_q.delete();
    push_seq(32'h300, 6);
    clk_n();
    chk("D_addr300", rom_addr_o, 32'h300);
    id_ready_i = 1'b1;
    drain("D_drain", 60, 1'b0);

    // Fetch PC wraps modulo 2^32
    redirect("E", 32'hFFFF_FFF8);
    push_seq(32'hFFFF_FFF8, 4);
    for (int k = 0; k < 3; k++) begin
      clk_n();
      e = 32'hFFFF_FFF8 + AW'(4 * k);
      chk("E_ce", rom_ce_o, 1);
      chk("E_addr", rom_addr_o, e);
      clk_p();
    end
    id_ready_i = 1'b1;
    drain("E_drain", 40, 1'b0);

    // Random ID backpressure: simultaneous push/pop at every occupancy
    redirect("G", 32'h1000);
    push_seq(32'h1000, 40);
    drain("G_drain", 600, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
